// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared opcode, phase and strobe definitions for the 8-bit RISC
//             CPU (sequencer, program counter, ALU, instruction register).
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int OP_W = 3;

    // Opcode encoding is fixed by the instruction set.
    localparam logic [OP_W-1:0] OP_HLT = 3'd0;
    localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_LDA = 3'd5;
    localparam logic [OP_W-1:0] OP_STO = 3'd6;
    localparam logic [OP_W-1:0] OP_JMP = 3'd7;

    // Eight fetch-execute phases; the counter wraps 7 -> 0 with no dead cycle.
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Bundle of every control strobe the sequencer drives.
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } strobe_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_decode
//  Purpose  : Purely combinational strobe decoder for the instruction
//             sequencer: (phase, opcode, zero, halted, enable) -> strobes.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  phase_e          i_phase,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_zero,
    input  logic            i_halted,
    input  logic            i_enable,
    output strobe_t         o_strobes
);

    logic w_alu;
    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;

    assign w_alu    = is_aluop(i_opcode);
    assign w_is_hlt = (i_opcode == OP_HLT);
    assign w_is_skz = (i_opcode == OP_SKZ);
    assign w_is_sto = (i_opcode == OP_STO);
    assign w_is_jmp = (i_opcode == OP_JMP);

    // Moore decode; halted overrides everything, a stall silences all strobes.
    always_comb begin
        o_strobes = '0;
        if (i_halted) begin
            o_strobes.halt = 1'b1;
        end else if (i_enable) begin
            case (i_phase)
                PH_INST_ADDR: begin
                    o_strobes.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    o_strobes.sel = 1'b1;
                    o_strobes.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    o_strobes.sel   = 1'b1;
                    o_strobes.rd    = 1'b1;
                    o_strobes.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    o_strobes.inc_pc = 1'b1;
                    o_strobes.halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    o_strobes.rd = w_alu;
                end
                PH_ALU_OP: begin
                    o_strobes.rd     = w_alu;
                    // Skip-if-zero: second PC increment jumps over the next instruction.
                    o_strobes.inc_pc = w_is_skz & i_zero;
                    o_strobes.ld_pc  = w_is_jmp;
                    o_strobes.data_e = w_is_sto;
                end
                PH_STORE: begin
                    o_strobes.rd     = w_alu;
                    o_strobes.ld_ac  = w_alu;
                    o_strobes.ld_pc  = w_is_jmp;
                    o_strobes.wr     = w_is_sto;
                    o_strobes.data_e = w_is_sto;
                end
                default: begin
                    o_strobes = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Eight-phase fetch-execute sequencer for the 8-bit RISC CPU.
//             Holds the phase counter and halted flag; drives PC, memory,
//             IR and accumulator strobes via cpu_seq_decode.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            resume,
    output logic [2:0]      phase,
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            ld_ac,
    output logic            wr,
    output logic            data_e,
    output logic            halt
);

    phase_e  r_phase;
    logic    r_halted;
    phase_e  w_phase_nxt;
    logic    w_halted_nxt;
    strobe_t w_dec;
    strobe_t w_out;

    // State register: phase counter and halted flag, async active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next state: resume only matters while halted, so it can never beat a halt trigger.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (r_halted) begin
            if (resume) begin
                w_halted_nxt = 1'b0;
            end
        end else if (enable) begin
            w_phase_nxt = phase_e'(r_phase + 3'd1);
            if ((r_phase == PH_OP_ADDR) && (opcode == OP_HLT)) begin
                w_halted_nxt = 1'b1;
            end
        end
    end

    cpu_seq_decode u_decode (
        .i_phase   (r_phase),
        .i_opcode  (opcode),
        .i_zero    (zero),
        .i_halted  (r_halted),
        .i_enable  (enable),
        .o_strobes (w_dec)
    );

    // While reset is low the outputs are forced combinationally so no partial strobe escapes.
    always_comb begin
        w_out = w_dec;
        if (!reset) begin
            w_out     = '0;
            w_out.sel = 1'b1;
        end
    end

    assign phase  = r_phase;
    assign sel    = w_out.sel;
    assign rd     = w_out.rd;
    assign ld_ir  = w_out.ld_ir;
    assign inc_pc = w_out.inc_pc;
    assign ld_pc  = w_out.ld_pc;
    assign ld_ac  = w_out.ld_ac;
    assign wr     = w_out.wr;
    assign data_e = w_out.data_e;
    assign halt   = w_out.halt;

    // Strobe invariants: no PC load/increment clash, no bus read/write clash, writes only at STORE.
    a_pc_excl: assert property (@(posedge clock) disable iff (!reset) !(ld_pc && inc_pc));
    a_rw_excl: assert property (@(posedge clock) disable iff (!reset) !(wr && rd));
    a_wr_ph7:  assert property (@(posedge clock) disable iff (!reset) wr |-> (phase == 3'd7));

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sequencer
//  Purpose  : Self-checking bench for cpu_sequencer: directed scenarios plus
//             randomized stimulus against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic            clock  = 1'b0;
    logic            reset  = 1'b0;
    logic            enable = 1'b0;
    logic [OP_W-1:0] opcode = '0;
    logic            zero   = 1'b0;
    logic            resume = 1'b0;
    logic [2:0]      phase;
    logic            sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: current phase number and halted flag.
    int m_ph  = 0;
    bit m_hlt = 1'b0;

    always #5 clock = ~clock;

    cpu_sequencer dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .opcode (opcode),
        .zero   (zero),
        .resume (resume),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    function automatic logic [31:0] dut_vec();
        return {20'd0, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    endfunction

    // Expected outputs, each strobe written as the set of phases/opcodes that raise it.
    function automatic logic [31:0] model_vec(input bit in_rst, input bit en,
                                              input logic [2:0] op, input bit z);
        bit alu, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        if (in_rst) return {20'd0, 3'd0, 9'b1_0000_0000};
        if (m_hlt)  return {20'd0, 3'(m_ph), 9'b0_0000_0001};
        if (!en)    return {20'd0, 3'(m_ph), 9'b0_0000_0000};
        alu    = (op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});
        e_sel  = (m_ph <= 3);
        e_rd   = (m_ph >= 1 && m_ph <= 3) || (alu && m_ph >= 5);
        e_ldir = (m_ph == 2) || (m_ph == 3);
        e_inc  = (m_ph == 4) || (m_ph == 6 && op == OP_SKZ && z);
        e_ldpc = (op == OP_JMP) && (m_ph >= 6);
        e_ldac = alu && (m_ph == 7);
        e_wr   = (op == OP_STO) && (m_ph == 7);
        e_de   = (op == OP_STO) && (m_ph >= 6);
        e_halt = (m_ph == 4) && (op == OP_HLT);
        return {20'd0, 3'(m_ph), e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
    endfunction

    function automatic void model_step(input bit en, input logic [2:0] op, input bit rs);
        if (m_hlt) begin
            if (rs) m_hlt = 1'b0;
        end else if (en) begin
            if (m_ph == 4 && op == OP_HLT) m_hlt = 1'b1;
            m_ph = (m_ph + 1) % 8;
        end
    endfunction

    // One clock: drive at the falling edge, compare mid-low, optionally pull reset mid-cycle.
    task automatic cycle(input string tag, input bit rn, input bit en, input logic [2:0] op,
                         input bit z, input bit rs, input bit mid_rst);
        reset  = rn;
        enable = en;
        opcode = op;
        zero   = z;
        resume = rs;
        if (!rn) begin
            m_ph  = 0;
            m_hlt = 1'b0;
        end
        #2;
        check_eq(tag, dut_vec(), model_vec(!reset, en, op, z));
        if (mid_rst) begin
            #1 reset = 1'b0;
            m_ph  = 0;
            m_hlt = 1'b0;
            #1 check_eq({tag, "_arst"}, dut_vec(), model_vec(1'b1, en, op, z));
        end
        if (reset) model_step(en, op, rs);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Run enabled cycles until the model reaches the target phase (bounded).
    task automatic goto_phase(input int ph, input logic [2:0] op);
        for (int i = 0; i < 20 && (m_ph != ph || m_hlt); i++)
            cycle("goto", 1'b1, 1'b1, op, 1'b0, m_hlt, 1'b0);
        check_eq("goto_phase", {29'd0, phase}, ph);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit pend;
        bit rn;
        bit mid;
        @(negedge clock);

        // Held in reset: forced outputs regardless of enable.
        cycle("rst_en0", 1'b0, 1'b0, OP_STO, 1'b0, 1'b0, 1'b0);
        cycle("rst_en1", 1'b0, 1'b1, OP_JMP, 1'b1, 1'b1, 1'b0);

        // Full instruction of each flavour from phase 0.
        for (int i = 0; i < 8; i++) cycle("add", 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
        check_eq("add_wrap", {29'd0, phase}, 0);
        for (int i = 0; i < 8; i++) cycle("skz_z1", 1'b1, 1'b1, OP_SKZ, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("skz_z0", 1'b1, 1'b1, OP_SKZ, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("jmp", 1'b1, 1'b1, OP_JMP, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("sto", 1'b1, 1'b1, OP_STO, 1'b1, 1'b0, 1'b0);

        // Halt at phase 4 (with a coincident resume that must lose), then sit halted.
        for (int i = 0; i < 4; i++) cycle("hlt_pre", 1'b1, 1'b1, OP_HLT, 1'b0, 1'b0, 1'b0);
        cycle("hlt_trig", 1'b1, 1'b1, OP_HLT, 1'b0, 1'b1, 1'b0);
        check_eq("halt_phase", {29'd0, phase}, 5);
        check_eq("halt_flag", {31'd0, halt}, 1);
        for (int i = 0; i < 20; i++)
            cycle("halted", 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycle("resume", 1'b1, 1'b0, OP_HLT, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("post_res", 1'b1, 1'b1, OP_HLT, 1'b0, 1'b0, 1'b0);
        check_eq("res_ph0_sel", {28'd0, phase, sel}, {28'd0, 3'd0, 1'b1});
        cycle("res_ph0", 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);

        // Stall three clocks at phase 3, then resume to phase 4.
        goto_phase(3, OP_ADD);
        for (int i = 0; i < 3; i++)
            cycle("stall", 1'b1, 1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0);
        check_eq("stall_phase", {29'd0, phase}, 3);
        cycle("unstall3", 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
        cycle("unstall4", 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);

        // Stall exactly on a HLT phase 4: no halt until the enabled cycle.
        goto_phase(4, OP_ADD);
        cycle("hlt_stall", 1'b1, 1'b0, OP_HLT, 1'b0, 1'b0, 1'b0);
        check_eq("hlt_stall_nohalt", {28'd0, phase, halt}, {28'd0, 3'd4, 1'b0});
        cycle("hlt_late", 1'b1, 1'b1, OP_HLT, 1'b0, 1'b0, 1'b0);
        cycle("hlt_late_res", 1'b1, 1'b1, OP_LDA, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a STO phase 6.
        goto_phase(6, OP_STO);
        cycle("sto6", 1'b1, 1'b1, OP_STO, 1'b0, 1'b0, 1'b1);
        cycle("sto_rst", 1'b0, 1'b1, OP_STO, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("post_rst", 1'b1, 1'b1, OP_XOR, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional mid-cycle resets.
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rn   = !pend;
            mid  = 1'b0;
            pend = 1'b0;
            if (rn && $urandom_range(0, 149) == 0) begin
                mid  = 1'b1;
                pend = 1'b1;
            end
            cycle("rnd", rn, $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, mid);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
